// File: rtl/lfsr_trit_stream.sv
// Pseudo-random balanced-trit source for the nonce path.
// A 64-bit XNOR Fibonacci LFSR feeds a bit collector. Each full collector is
// mapped to 2-bit trits and offered on a registered valid/ready output. The
// LFSR only advances while bits are being collected. The trit stream is
// therefore a pure function of the seed, independent of backpressure.
module lfsr_trit_stream #(
    parameter int unsigned N_TRITS      = 27,
    parameter int unsigned BITS_PER_CLK = 1
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_en,
    input  logic                   i_seed_load,
    input  logic [63:0]            i_seed,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [2*N_TRITS-1:0]   o_rnd_trits,
    output logic                   o_seed_err
);

    localparam int unsigned W        = 2 * N_TRITS;
    localparam int unsigned CW       = $clog2(W + 1);
    localparam logic [CW-1:0] CntFull = CW'(W);

    logic [63:0]   lfsr_q, lfsr_d;
    logic [W-1:0]  coll_q, coll_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [W-1:0]  trits_q, trits_d;
    logic          seed_err_q, seed_err_d;

    logic [W-1:0]  mapped;
    logic [31:0]   room;
    logic          slot_free;
    logic          fb;

    // Map collector bit pairs onto trits; the pattern 10 folds into 00.
    always_comb begin
        mapped = '0;
        for (int unsigned i = 0; i < N_TRITS; i++) begin
            mapped[2*i]   = coll_q[2*i];
            mapped[2*i+1] = coll_q[2*i+1] & coll_q[2*i];
        end
    end

    // Next state: seed load beats transfer; transfer beats collection.
    always_comb begin
        lfsr_d     = lfsr_q;
        coll_d     = coll_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        trits_d    = trits_q;
        seed_err_d = 1'b0;
        fb         = 1'b0;
        slot_free  = ~valid_q | i_ready;
        room       = W - 32'(cnt_q);

        // A completed handshake empties the slot.
        // A transfer below can refill it.
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        if (i_seed_load) begin
            // The all-ones seed is the XNOR lock-up state, so it is replaced by zero.
            if (i_seed == '1) begin
                lfsr_d     = '0;
                seed_err_d = 1'b1;
            end else begin
                lfsr_d = i_seed;
            end
            cnt_d = '0;
        end else if (cnt_q == CntFull) begin
            // A full collector with no free slot stalls everything.
            if (slot_free) begin
                trits_d = mapped;
                valid_d = 1'b1;
                cnt_d   = '0;
            end
        end else if (i_en) begin
            // Step at most the bits still missing, so no generated bit is lost.
            for (int unsigned k = 0; k < BITS_PER_CLK; k++) begin
                if (k < room) begin
                    fb     = ~(lfsr_d[63] ^ lfsr_d[62] ^ lfsr_d[60] ^ lfsr_d[59]);
                    lfsr_d = {lfsr_d[62:0], fb};
                    coll_d = {coll_d[W-2:0], fb};
                    cnt_d  = cnt_d + CW'(1);
                end
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            lfsr_q     <= '0;
            coll_q     <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            trits_q    <= '0;
            seed_err_q <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            coll_q     <= coll_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            trits_q    <= trits_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_rnd_trits = trits_q;
    assign o_seed_err  = seed_err_q;

endmodule
